// File: rtl/knight_anim_pkg.sv
// Shared types and constants for the animated knight sprite address path.
package knight_anim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DONE
    } anim_state_t;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned COORD_W  = 10;
    // One extra bit so px + SPRITE_W cannot wrap back into the visible area.
    localparam int unsigned HIT_W    = COORD_W + 1;

    function automatic int unsigned frame_base(input int unsigned f,
                                               input int unsigned sprite_w,
                                               input int unsigned sprite_h);
        return f * sprite_w * sprite_h;
    endfunction

endpackage

// File: rtl/knight_anim_addr_gen_if.sv
// Scan/position inputs and ROM address/status outputs of the sprite address stage.
interface knight_anim_addr_gen_if #(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned FRAME_W = 3
);
    logic [9:0]         DrawX;
    logic [9:0]         DrawY;
    logic               blank;
    logic               vsync;
    logic [9:0]         pos_x;
    logic [9:0]         pos_y;
    logic               flip;
    logic               start;
    logic               loop;
    logic [ADDR_W-1:0]  rom_address;
    logic               sprite_on;
    logic [FRAME_W-1:0] frame_idx;
    logic               busy;
    logic               anim_done;

    modport master (
        output DrawX, DrawY, blank, vsync, pos_x, pos_y, flip, start, loop,
        input  rom_address, sprite_on, frame_idx, busy, anim_done
    );

    modport slave (
        input  DrawX, DrawY, blank, vsync, pos_x, pos_y, flip, start, loop,
        output rom_address, sprite_on, frame_idx, busy, anim_done
    );
endinterface

// File: rtl/anim_frame_fsm.sv
// Animation sequencer: vsync edge detect, frame divider and frame index FSM.
module anim_frame_fsm
    import knight_anim_pkg::*;
#(
    parameter int unsigned NUM_FRAMES = 8,
    parameter int unsigned FRAME_DIV  = 6,
    parameter int unsigned FRAME_W    = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               vsync_i,
    input  logic               start_i,
    input  logic               loop_i,
    output logic               frame_tick_o,
    output logic [FRAME_W-1:0] frame_idx_o,
    output logic               busy_o,
    output logic               anim_done_o
);

    localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(FRAME_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

    anim_state_t        state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               vsync_q;
    logic               frame_tick;

    assign frame_tick = vsync_q & ~vsync_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            frame_q   <= '0;
            vsync_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            frame_q   <= frame_d;
            vsync_q   <= vsync_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        frame_d   = frame_q;
        unique case (state_q)
            IDLE: begin
                frame_d   = '0;
                div_cnt_d = '0;
                if (start_i) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // A restart pulse wins over a coincident frame tick.
                if (start_i) begin
                    frame_d   = '0;
                    div_cnt_d = '0;
                end else if (frame_tick) begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d = '0;
                        if (frame_q != FRAME_LAST) begin
                            frame_d = frame_q + 1'b1;
                        end else if (loop_i) begin
                            frame_d = '0;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (start_i) begin
                    state_d   = PLAY;
                    frame_d   = '0;
                    div_cnt_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                frame_d   = '0;
                div_cnt_d = '0;
            end
        endcase
    end

    assign frame_tick_o = frame_tick;
    assign frame_idx_o  = frame_q;
    assign busy_o       = (state_q == PLAY);
    assign anim_done_o  = (state_q == DONE);

endmodule

// File: rtl/knight_anim_addr_gen.sv
// Sprite hit test and ROM address generation for one animated sprite,
// registered so address and in-sprite flag appear one pixel clock after DrawX/DrawY.
module knight_anim_addr_gen
    import knight_anim_pkg::*;
#(
    parameter int unsigned SPRITE_W   = 50,
    parameter int unsigned SPRITE_H   = 64,
    parameter int unsigned NUM_FRAMES = 8,
    parameter int unsigned FRAME_DIV  = 6,
    parameter int unsigned ADDR_W     = 15
) (
    input  logic                   vga_clk,
    input  logic                   reset,
    knight_anim_addr_gen_if.slave  bus
);

    localparam int unsigned FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    logic [FRAME_W-1:0] frame_idx;
    logic               frame_tick;
    logic               busy;
    logic               anim_done;

    logic [COORD_W-1:0] px_q, px_d;
    logic [COORD_W-1:0] py_q, py_d;
    logic               flip_q, flip_d;
    logic [ADDR_W-1:0]  rom_address_q, rom_address_d;
    logic               sprite_on_q, sprite_on_d;

    logic [HIT_W-1:0]   x_ext, y_ext, px_ext, py_ext;
    logic [HIT_W-1:0]   col, row;
    logic [31:0]        addr_full;
    logic               hit;

    anim_frame_fsm #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_DIV  (FRAME_DIV),
        .FRAME_W    (FRAME_W)
    ) u_anim_frame_fsm (
        .clk_i        (vga_clk),
        .reset_i      (reset),
        .vsync_i      (bus.vsync),
        .start_i      (bus.start),
        .loop_i       (bus.loop),
        .frame_tick_o (frame_tick),
        .frame_idx_o  (frame_idx),
        .busy_o       (busy),
        .anim_done_o  (anim_done)
    );

    // Geometry only moves at the start of a video frame to avoid tearing.
    always_comb begin
        px_d   = px_q;
        py_d   = py_q;
        flip_d = flip_q;
        if (frame_tick) begin
            px_d   = bus.pos_x;
            py_d   = bus.pos_y;
            flip_d = bus.flip;
        end
    end

    always_comb begin
        x_ext  = {1'b0, bus.DrawX};
        y_ext  = {1'b0, bus.DrawY};
        px_ext = {1'b0, px_q};
        py_ext = {1'b0, py_q};

        hit = bus.blank
            & (x_ext >= px_ext) & (x_ext < px_ext + HIT_W'(SPRITE_W))
            & (y_ext >= py_ext) & (y_ext < py_ext + HIT_W'(SPRITE_H));

        col = x_ext - px_ext;
        row = y_ext - py_ext;
        if (flip_q) begin
            col = HIT_W'(SPRITE_W - 1) - col;
        end

        addr_full = frame_base(32'(frame_idx), SPRITE_W, SPRITE_H)
                  + 32'(row) * SPRITE_W + 32'(col);

        sprite_on_d   = hit;
        rom_address_d = hit ? addr_full[ADDR_W-1:0] : '0;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            px_q          <= '0;
            py_q          <= '0;
            flip_q        <= 1'b0;
            rom_address_q <= '0;
            sprite_on_q   <= 1'b0;
        end else begin
            px_q          <= px_d;
            py_q          <= py_d;
            flip_q        <= flip_d;
            rom_address_q <= rom_address_d;
            sprite_on_q   <= sprite_on_d;
        end
    end

    assign bus.rom_address = rom_address_q;
    assign bus.sprite_on   = sprite_on_q;
    assign bus.frame_idx   = frame_idx;
    assign bus.busy        = busy;
    assign bus.anim_done   = anim_done;

endmodule

// File: tb/tb_knight_anim_addr_gen.sv
// Scoreboard bench for knight_anim_addr_gen: stimulus queues expected outputs,
// a negedge monitor pops and compares them in the cycle they are due.
module tb_knight_anim_addr_gen;

    logic vga_clk = 1'b0;
    logic reset;

    always #5 vga_clk = ~vga_clk;

    knight_anim_addr_gen_if #(.ADDR_W(15), .FRAME_W(3)) bus ();

    knight_anim_addr_gen #(
        .SPRITE_W   (50),
        .SPRITE_H   (64),
        .NUM_FRAMES (8),
        .FRAME_DIV  (6),
        .ADDR_W     (15)
    ) dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        int    cyc;
        string name;
        int    addr;
        int    on;
        int    f;
        int    busy;
        int    done;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc_cnt = 0;

    always @(posedge vga_clk) cyc_cnt <= cyc_cnt + 1;

    task automatic cmp(input string n, input string field, input logic [31:0] act,
                       input int req);
        checks++;
        if (act !== 32'(req)) begin
            errors++;
            $display("FAIL %s.%s actual=%0d required=%0d", n, field, act, req);
        end
    endtask

    // Monitor: compares the queued expectation that falls due in this cycle.
    always @(negedge vga_clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s missed actual=cycle%0d required=cycle%0d", e.name, cyc_cnt, e.cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
            e = sb.pop_front();
            cmp(e.name, "rom_address", 32'(bus.rom_address), e.addr);
            cmp(e.name, "sprite_on",   32'(bus.sprite_on),   e.on);
            cmp(e.name, "frame_idx",   32'(bus.frame_idx),   e.f);
            cmp(e.name, "busy",        32'(bus.busy),        e.busy);
            cmp(e.name, "anim_done",   32'(bus.anim_done),   e.done);
        end
    end

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic expect_next(input string n, input int addr, input int on, input int f,
                               input int b, input int d);
        exp_t e;
        e.cyc  = cyc_cnt + 1;
        e.name = n;
        e.addr = addr;
        e.on   = on;
        e.f    = f;
        e.busy = b;
        e.done = d;
        sb.push_back(e);
    endtask

    task automatic tick();
        bus.vsync = 1'b0;
        step();
        bus.vsync = 1'b1;
        step();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic probe(input string n, input logic bl, input int x, input int y,
                         input int addr, input int on, input int f, input int b, input int d);
        bus.blank = bl;
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        expect_next(n, addr, on, f, b, d);
        step();
        bus.blank = 1'b0;
    endtask

    task automatic status(input string n, input int f, input int b, input int d);
        bus.blank = 1'b0;
        expect_next(n, 0, 0, f, b, d);
        step();
    endtask

    task automatic pulse_start(input string n, input int f, input int b, input int d);
        bus.start = 1'b1;
        expect_next(n, 0, 0, f, b, d);
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        bus.DrawX = '0;
        bus.DrawY = '0;
        bus.blank = 1'b0;
        bus.vsync = 1'b1;
        bus.pos_x = '0;
        bus.pos_y = '0;
        bus.flip  = 1'b0;
        bus.start = 1'b0;
        bus.loop  = 1'b0;

        // Reset held 3 cycles with vsync toggling underneath.
        step();
        bus.vsync = 1'b0;
        step();
        bus.vsync = 1'b1;
        expect_next("reset", 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        tick();
        status("idle_tick", 0, 0, 0);

        // Hit test and address at frame 0, no flip.
        bus.pos_x = 10'd100;
        bus.pos_y = 10'd200;
        tick();
        probe("hit_origin",  1'b1, 100, 200, 0,    1, 0, 0, 0);
        probe("hit_corner",  1'b1, 149, 263, 3199, 1, 0, 0, 0);
        probe("miss_right",  1'b1, 150, 200, 0,    0, 0, 0, 0);
        probe("miss_above",  1'b1, 100, 199, 0,    0, 0, 0, 0);
        probe("blanked",     1'b0, 120, 210, 0,    0, 0, 0, 0);

        // Flip at frame 2.
        pulse_start("start_idle", 0, 1, 0);
        bus.pos_x = '0;
        bus.pos_y = '0;
        bus.flip  = 1'b1;
        ticks(12);
        probe("flip_f2_a", 1'b1, 0,  0, 6449, 1, 2, 1, 0);
        probe("flip_f2_b", 1'b1, 49, 1, 6450, 1, 2, 1, 0);

        // One-shot animation.
        bus.flip = 1'b0;
        bus.loop = 1'b0;
        pulse_start("restart_play", 0, 1, 0);
        for (int t = 1; t <= 48; t++) begin
            tick();
            if (t % 6 == 0 || t % 6 == 5) begin
                status($sformatf("noloop_t%0d", t), (t == 48) ? 7 : t / 6,
                       (t == 48) ? 0 : 1, (t == 48) ? 1 : 0);
            end
        end
        ticks(2);
        status("done_hold", 7, 0, 1);

        // Looping animation.
        bus.loop = 1'b1;
        pulse_start("restart_done", 0, 1, 0);
        for (int t = 1; t <= 48; t++) begin
            tick();
            if (t == 42 || t == 48) begin
                status($sformatf("loop_t%0d", t), (t == 42) ? 7 : 0, 1, 0);
            end
        end
        ticks(30);
        status("loop_f5", 5, 1, 0);

        // Start coincident with a frame tick: restart wins, divider cleared.
        bus.vsync = 1'b0;
        bus.start = 1'b1;
        expect_next("start_on_tick", 0, 0, 0, 1, 0);
        step();
        bus.start = 1'b0;
        bus.vsync = 1'b1;
        step();
        ticks(5);
        status("div_cleared", 0, 1, 0);
        tick();
        status("div_wrap", 1, 1, 0);

        // Clipping at bottom-right; frame 1, one tick into the divider.
        bus.pos_x = 10'd620;
        bus.pos_y = 10'd450;
        tick();
        probe("clip_corner", 1'b1, 639, 479, 3200 + 29 * 50 + 19, 1, 1, 1, 0);
        probe("clip_left",   1'b1, 619, 479, 0, 0, 1, 1, 0);
        probe("no_wrap",     1'b1, 0,   0,   0, 0, 1, 1, 0);

        // Reset in PLAY at frame 3.
        pulse_start("restart_for_reset", 0, 1, 0);
        ticks(18);
        status("play_f3", 3, 1, 0);
        reset     = 1'b1;
        bus.blank = 1'b1;
        bus.DrawX = 10'd639;
        bus.DrawY = 10'd479;
        expect_next("reset_mid", 0, 0, 0, 0, 0);
        step();
        reset     = 1'b0;
        bus.blank = 1'b0;
        probe("pos_cleared", 1'b1, 0, 0, 0, 1, 0, 0, 0);
        tick();
        status("idle_after_reset", 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
